instr_sequencer: RTL
====================

// Module: instr_sequencer
// PURPOSE
//  Moore FSM that decodes one 16-bit Simple RISC Machine instruction and steps the datapath through it.
//  It drives the datapath controls: register file, loada/loadb/loadc/loads, asel/bsel, shift, ALUop and datapath_in.
//  Host handshake: s starts an instruction, w reports idle. One instruction in flight at a time.
// PARAMETERS
//  DATA_W  16  datapath/instruction width
//  RA_W     3  register-address width (R0..R7)
// PORTS
//  clk           in   1       rising-edge clock
//  reset_n       in   1       synchronous active-low reset
//  s             in   1       start request
//  instr         in   DATA_W  instruction; sampled only when s=1 and state=WAIT
//  w             out  1       1 only in WAIT (ready)
//  err           out  1       1-cycle pulse on an unsupported encoding
//  readnum       out  RA_W    register-file read address
//  writenum      out  RA_W    register-file write address
//  write         out  1       register-file write enable
//  vsel          out  1       1: regfile data_in=datapath_in (imm); 0: =datapath_out (C)
//  datapath_in   out  DATA_W  sign-extended imm8 of latched instruction
//  loada/loadb   out  1       pipeline A/B load enables
//  asel/bsel     out  1       1: A operand forced to 0 / B from shifter (bsel always 0)
//  shift         out  2       shifter op
//  ALUop         out  2       00 add, 01 sub, 10 and, 11 not-B
//  loadc/loads   out  1       C register / status (Z) load enables
// BEHAVIOUR
//  Encoding: op=[15:13], sub=[12:11], Rn=[10:8], Rd=[7:5], sh=[4:3], Rm=[2:0], imm8=[7:0].
//  Supported: 110/10 MOV Rn,#imm8; 110/00 MOV Rd,Rm{sh}; 101/00 ADD; 101/01 CMP; 101/10 AND; 101/11 MVN.
//  On WAIT with s=1 the edge latches instr into IR; instr is ignored in every other state.
//  States/transitions (one per clock):
//   WAIT -s-> DECODE; WAIT -!s-> WAIT
//   DECODE: MOV imm->WR_IMM; ADD/CMP/AND->GET_A; MOV reg/MVN->GET_B; other->WAIT with err=1
//   WR_IMM->WAIT;  GET_A->GET_B;  GET_B->EXEC
//   EXEC: CMP->WAIT; else->WR_REG;  WR_REG->WAIT
//  Outputs per state (all unlisted controls 0):
//   WAIT: w=1.  WR_IMM: write=1, vsel=1, writenum=Rn.
//   GET_A: readnum=Rn, loada=1.  GET_B: readnum=Rm, loadb=1.
//   EXEC: shift=sh; ALUop=sub for op 101, 00 for MOV reg; asel=1 for MOV reg and MVN;
//         loadc=1, except CMP: loads=1, loadc=0.
//   WR_REG: write=1, vsel=0, writenum=Rd.
//  datapath_in = {{8{IR[7]}},IR[7:0]} continuously (0x0000 after reset).
//  Latency from the sampling edge to w=1: MOV imm 2; CMP 4; MOV reg/MVN 4; ADD/AND 5 clocks. err case 1.
//  Holding s=1 issues back-to-back: the next instruction is sampled on the edge that leaves WAIT.
//  write and loads never assert in the same cycle. Regfile write is never issued for CMP or err.
//  Reset (reset_n=0 at an edge, any state, even mid-instruction): state=WAIT, IR=0, w=1, err=0, all
//   enables 0, addresses 0. The aborted instruction has no further effect.
//  reset_n has priority over s.
// TESTING
//  reset_n=0 for 2 clk mid-ADD (in GET_B) -> next cycle w=1, write=0, loads=0; no WR_REG occurs.
//  s=1, instr=0xD0FB (MOV R0,#-5) -> DECODE, WR_IMM(write=1,vsel=1,writenum=0,datapath_in=0xFFFB), w=1 after 2 clk.
//  instr=0xA148 (ADD R2,R1,R0 LSL#1) -> GET_A rd=1, GET_B rd=0, EXEC shift=01 ALUop=00 loadc=1, WR_REG writenum=2.
//  instr=0xA900 (CMP R1,R0) -> EXEC loads=1 ALUop=01 loadc=0; write never 1; w=1 4 clk after sampling.
//  instr=0x0000 -> err=1 for exactly 1 cycle in DECODE, back in WAIT next clk, no enables asserted.
//  s held 1, 0xD0FB then 0xB8E0 (MVN R7,R0) -> second sampled on WAIT edge; EXEC asel=1 ALUop=11; WR_REG writenum=7.

Source files
------------

// File: rtl/instr_sequencer.sv
// Control sequencer for the Simple RISC Machine: latches one instruction and steps the
// register file / datapath through it, one state per clock, with registered control outputs.
module instr_sequencer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RA_W   = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s,
    input  logic [DATA_W-1:0] instr,
    output logic              w,
    output logic              err,
    output logic [RA_W-1:0]   readnum,
    output logic [RA_W-1:0]   writenum,
    output logic              write,
    output logic              vsel,
    output logic [DATA_W-1:0] datapath_in,
    output logic              loada,
    output logic              loadb,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        shift,
    output logic [1:0]        ALUop,
    output logic              loadc,
    output logic              loads
);

    localparam int unsigned IMM_W = 8;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_WR_IMM = 3'd2,
        S_GET_A  = 3'd3,
        S_GET_B  = 3'd4,
        S_EXEC   = 3'd5,
        S_WR_REG = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_MOVI = 3'd0,
        C_MOVR = 3'd1,
        C_ADD  = 3'd2,
        C_CMP  = 3'd3,
        C_AND  = 3'd4,
        C_MVN  = 3'd5,
        C_BAD  = 3'd6
    } iclass_t;

    // Map op/sub fields onto the supported instruction classes.
    function automatic iclass_t classify(input logic [DATA_W-1:0] ir);
        logic [2:0] op;
        logic [1:0] sb;
        iclass_t    c;
        op = ir[15:13];
        sb = ir[12:11];
        c  = C_BAD;
        if (op == 3'b110 && sb == 2'b10) begin
            c = C_MOVI;
        end else if (op == 3'b110 && sb == 2'b00) begin
            c = C_MOVR;
        end else if (op == 3'b101) begin
            case (sb)
                2'b00:   c = C_ADD;
                2'b01:   c = C_CMP;
                2'b10:   c = C_AND;
                default: c = C_MVN;
            endcase
        end
        return c;
    endfunction

    state_t              r_state;
    logic [DATA_W-1:0]   r_ir;
    logic                r_w;
    logic                r_err;
    logic [RA_W-1:0]     r_readnum;
    logic [RA_W-1:0]     r_writenum;
    logic                r_write;
    logic                r_vsel;
    logic                r_loada;
    logic                r_loadb;
    logic                r_asel;
    logic [1:0]          r_shift;
    logic [1:0]          r_aluop;
    logic                r_loadc;
    logic                r_loads;

    state_t              w_state_nxt;
    logic [DATA_W-1:0]   w_ir_nxt;
    iclass_t             w_cls;
    iclass_t             w_cls_nxt;
    logic                w_nxt_w;
    logic                w_nxt_err;
    logic [RA_W-1:0]     w_nxt_readnum;
    logic [RA_W-1:0]     w_nxt_writenum;
    logic                w_nxt_write;
    logic                w_nxt_vsel;
    logic                w_nxt_loada;
    logic                w_nxt_loadb;
    logic                w_nxt_asel;
    logic [1:0]          w_nxt_shift;
    logic [1:0]          w_nxt_aluop;
    logic                w_nxt_loadc;
    logic                w_nxt_loads;

    // Next state, plus the Moore outputs of that next state so the outputs come straight from flops.
    always_comb begin
        w_state_nxt    = r_state;
        w_ir_nxt       = r_ir;
        w_cls          = classify(r_ir);
        w_nxt_w        = 1'b0;
        w_nxt_err      = 1'b0;
        w_nxt_readnum  = '0;
        w_nxt_writenum = '0;
        w_nxt_write    = 1'b0;
        w_nxt_vsel     = 1'b0;
        w_nxt_loada    = 1'b0;
        w_nxt_loadb    = 1'b0;
        w_nxt_asel     = 1'b0;
        w_nxt_shift    = 2'b00;
        w_nxt_aluop    = 2'b00;
        w_nxt_loadc    = 1'b0;
        w_nxt_loads    = 1'b0;

        case (r_state)
            S_WAIT: begin
                if (s) begin
                    w_state_nxt = S_DECODE;
                    w_ir_nxt    = instr;
                end
            end
            S_DECODE: begin
                case (w_cls)
                    C_MOVI:               w_state_nxt = S_WR_IMM;
                    C_ADD, C_CMP, C_AND:  w_state_nxt = S_GET_A;
                    C_MOVR, C_MVN:        w_state_nxt = S_GET_B;
                    default:              w_state_nxt = S_WAIT;
                endcase
            end
            S_WR_IMM: w_state_nxt = S_WAIT;
            S_GET_A:  w_state_nxt = S_GET_B;
            S_GET_B:  w_state_nxt = S_EXEC;
            S_EXEC:   w_state_nxt = (w_cls == C_CMP) ? S_WAIT : S_WR_REG;
            S_WR_REG: w_state_nxt = S_WAIT;
            default:  w_state_nxt = S_WAIT;
        endcase

        w_cls_nxt = classify(w_ir_nxt);

        case (w_state_nxt)
            S_WAIT:   w_nxt_w = 1'b1;
            S_DECODE: w_nxt_err = (w_cls_nxt == C_BAD);
            S_WR_IMM: begin
                w_nxt_write    = 1'b1;
                w_nxt_vsel     = 1'b1;
                w_nxt_writenum = RA_W'(w_ir_nxt[10:8]);
            end
            S_GET_A: begin
                w_nxt_readnum = RA_W'(w_ir_nxt[10:8]);
                w_nxt_loada   = 1'b1;
            end
            S_GET_B: begin
                w_nxt_readnum = RA_W'(w_ir_nxt[2:0]);
                w_nxt_loadb   = 1'b1;
            end
            S_EXEC: begin
                w_nxt_shift = w_ir_nxt[4:3];
                w_nxt_aluop = (w_cls_nxt == C_MOVR) ? 2'b00 : w_ir_nxt[12:11];
                w_nxt_asel  = (w_cls_nxt == C_MOVR) || (w_cls_nxt == C_MVN);
                if (w_cls_nxt == C_CMP) begin
                    w_nxt_loads = 1'b1;
                end else begin
                    w_nxt_loadc = 1'b1;
                end
            end
            S_WR_REG: begin
                w_nxt_write    = 1'b1;
                w_nxt_writenum = RA_W'(w_ir_nxt[7:5]);
            end
            default: w_nxt_w = 1'b0;
        endcase
    end

    // State, instruction and control registers; reset wins over a pending start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_WAIT;
            r_ir       <= '0;
            r_w        <= 1'b1;
            r_err      <= 1'b0;
            r_readnum  <= '0;
            r_writenum <= '0;
            r_write    <= 1'b0;
            r_vsel     <= 1'b0;
            r_loada    <= 1'b0;
            r_loadb    <= 1'b0;
            r_asel     <= 1'b0;
            r_shift    <= 2'b00;
            r_aluop    <= 2'b00;
            r_loadc    <= 1'b0;
            r_loads    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ir       <= w_ir_nxt;
            r_w        <= w_nxt_w;
            r_err      <= w_nxt_err;
            r_readnum  <= w_nxt_readnum;
            r_writenum <= w_nxt_writenum;
            r_write    <= w_nxt_write;
            r_vsel     <= w_nxt_vsel;
            r_loada    <= w_nxt_loada;
            r_loadb    <= w_nxt_loadb;
            r_asel     <= w_nxt_asel;
            r_shift    <= w_nxt_shift;
            r_aluop    <= w_nxt_aluop;
            r_loadc    <= w_nxt_loadc;
            r_loads    <= w_nxt_loads;
        end
    end

    assign w           = r_w;
    assign err         = r_err;
    assign readnum     = r_readnum;
    assign writenum    = r_writenum;
    assign write       = r_write;
    assign vsel        = r_vsel;
    assign datapath_in = {{(DATA_W-IMM_W){r_ir[IMM_W-1]}}, r_ir[IMM_W-1:0]};
    assign loada       = r_loada;
    assign loadb       = r_loadb;
    assign asel        = r_asel;
    assign bsel        = 1'b0;
    assign shift       = r_shift;
    assign ALUop       = r_aluop;
    assign loadc       = r_loadc;
    assign loads       = r_loads;

endmodule
